// File: rtl/watch_pkg.sv
// Shared definitions for the watch front-end: FSM states, field widths/limits
// and the sel encodings used to drive the display blink.
package watch_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SET_H,
    ST_SET_M,
    ST_SET_S,
    ST_LOAD
  } state_t;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned SEC_W  = 6;

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_HOUR = 2'd1;
  localparam logic [1:0] SEL_MIN  = 2'd2;
  localparam logic [1:0] SEL_SEC  = 2'd3;

  // Increment with wrap; anything at or above max (including garbage) goes to 0.
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a synchronized button; history resets high so a
// button held through reset does not register as a press.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press_c
);

  logic btn_q;

  always_ff @(posedge clk) begin
    if (rst) btn_q <= 1'b1;
    else     btn_q <= btn;
  end

  assign press_c = btn & ~btn_q;

endmodule

// File: rtl/watch_setter.sv
// Watch front-end: one-second prescaler in run mode, two-button time editor
// with a single-cycle load strobe back into the watch.
module watch_setter
  import watch_pkg::*;
#(
  parameter int unsigned DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] hour_cur,
  input  logic [5:0] min_cur,
  input  logic [5:0] sec_cur,
  output logic       ci,
  output logic       ld,
  output logic [4:0] hour_in,
  output logic [5:0] min_in,
  output logic [5:0] sec_in,
  output logic [1:0] sel,
  output logic       editing
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOUR_W-1:0] hour_d;
  logic [MIN_W-1:0]  min_d;
  logic [SEC_W-1:0]  sec_d;
  logic              ci_d, ld_d, editing_d;
  logic [1:0]        sel_d;
  logic              mode_press, inc_press;

  btn_edge u_mode_edge (.clk(clk), .rst(rst), .btn(btn_mode), .press_c(mode_press));
  btn_edge u_inc_edge  (.clk(clk), .rst(rst), .btn(btn_inc),  .press_c(inc_press));

  // Next state, prescaler and edit registers; mode always beats inc.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    hour_d  = hour_in;
    min_d   = min_in;
    sec_d   = sec_in;
    unique case (state_q)
      ST_RUN: begin
        if (mode_press) begin
          state_d = ST_SET_H;
          hour_d  = hour_cur;
          min_d   = min_cur;
          sec_d   = sec_cur;
        end else begin
          cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
      end
      ST_SET_H: begin
        if (mode_press)     state_d = ST_SET_M;
        else if (inc_press) hour_d  = HOUR_W'(wrap_inc(6'(hour_in), 6'(HOUR_MAX)));
      end
      ST_SET_M: begin
        if (mode_press)     state_d = ST_SET_S;
        else if (inc_press) min_d   = MIN_W'(wrap_inc(min_in, MIN_MAX));
      end
      ST_SET_S: begin
        if (mode_press)     state_d = ST_LOAD;
        else if (inc_press) sec_d   = SEC_W'(wrap_inc(sec_in, SEC_MAX));
      end
      ST_LOAD: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase

    ci_d      = (state_d == ST_RUN) && (cnt_d == CNT_LAST);
    ld_d      = (state_d == ST_LOAD);
    editing_d = (state_d != ST_RUN);
    unique case (state_d)
      ST_SET_H: sel_d = SEL_HOUR;
      ST_SET_M: sel_d = SEL_MIN;
      ST_SET_S: sel_d = SEL_SEC;
      default:  sel_d = SEL_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      ci      <= 1'b0;
      ld      <= 1'b0;
      sel     <= SEL_NONE;
      editing <= 1'b0;
      hour_in <= '0;
      min_in  <= '0;
      sec_in  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ci      <= ci_d;
      ld      <= ld_d;
      sel     <= sel_d;
      editing <= editing_d;
      hour_in <= hour_d;
      min_in  <= min_d;
      sec_in  <= sec_d;
    end
  end

endmodule
